// File: rtl/pll_cfg_pkg.sv
// Shared types and constants for the PLL APB configuration sequencer.
package pll_cfg_pkg;

  localparam int unsigned ADDR_W            = 5;
  localparam int unsigned DATA_W            = 16;
  localparam int unsigned DEF_READY_TIMEOUT = 255;
  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 65535;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RST_PLL,
    WAIT_LOCK,
    RESP
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_apb_cfg_if.sv
// Command/response handshake plus APB requester bus of the PLL config block.
interface pll_apb_cfg_if;
  import pll_cfg_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_commit;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] apb_addr;
  logic              apb_sel;
  logic              apb_en;
  logic              apb_write;
  logic [DATA_W-1:0] apb_wdata;
  logic [DATA_W-1:0] apb_rdata;
  logic              apb_ready;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_commit, apb_rdata, apb_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           apb_addr, apb_sel, apb_en, apb_write, apb_wdata
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_commit, apb_rdata, apb_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           apb_addr, apb_sel, apb_en, apb_write, apb_wdata
  );

endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the APB clock domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pll_apb_cfg.sv
// Sequences one APB access to the PLL per command, optionally followed by a
// PLL reset pulse and a bounded wait for lock before reporting completion.
module pll_apb_cfg
  import pll_cfg_pkg::*;
#(
  parameter int unsigned READY_TIMEOUT = DEF_READY_TIMEOUT,
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT
) (
  input  logic          apb_clk,
  input  logic          apb_rst_n,
  pll_apb_cfg_if.slave  bus,
  output logic          pll_rst,
  input  logic          pll_lock
);

  localparam int unsigned CNT_W = $clog2(max3(READY_TIMEOUT, RST_CYCLES, LOCK_TIMEOUT) + 1);

  state_t           state;
  state_t           state_next;
  logic             err_next;
  logic [CNT_W-1:0] cnt;
  logic             commit_q;
  logic             lock_sync;

  pll_lock_sync u_lock_sync (
    .clk      (apb_clk),
    .rst_n    (apb_rst_n),
    .async_in (pll_lock),
    .sync_out (lock_sync)
  );

  always_ff @(posedge apb_clk) begin
    if (!apb_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE:      if (bus.cmd_valid) state_next = SETUP;
      SETUP:     state_next = ACCESS;
      ACCESS: begin
        if (bus.apb_ready) begin
          state_next = commit_q ? RST_PLL : RESP;
        end else if (cnt == CNT_W'(READY_TIMEOUT - 1)) begin
          state_next = RESP;
          err_next   = 1'b1;
        end
      end
      RST_PLL:   if (cnt == CNT_W'(RST_CYCLES - 1)) state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_next = RESP;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_next = RESP;
          err_next   = 1'b1;
        end
      end
      RESP:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // One counter serves all three timed states; it restarts on every state change.
  always_ff @(posedge apb_clk) begin
    if (!apb_rst_n)              cnt <= '0;
    else if (state_next != state) cnt <= '0;
    else                          cnt <= cnt + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge apb_clk) begin
    if (!apb_rst_n) begin
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.apb_sel   <= 1'b0;
      bus.apb_en    <= 1'b0;
      bus.apb_write <= 1'b0;
      bus.apb_addr  <= '0;
      bus.apb_wdata <= '0;
      pll_rst       <= 1'b0;
      commit_q      <= 1'b0;
    end else begin
      bus.cmd_ready <= (state_next == IDLE);
      bus.apb_sel   <= (state_next == SETUP) || (state_next == ACCESS);
      bus.apb_en    <= (state_next == ACCESS);
      pll_rst       <= (state_next == RST_PLL);
      bus.rsp_valid <= (state_next == RESP);
      bus.rsp_err   <= (state_next == RESP) && err_next;
      if (state == IDLE && bus.cmd_valid) begin
        bus.apb_addr  <= bus.cmd_addr;
        bus.apb_wdata <= bus.cmd_wdata;
        bus.apb_write <= bus.cmd_write;
        commit_q      <= bus.cmd_write && bus.cmd_commit;
        bus.rsp_rdata <= '0;
      end
      if (state == ACCESS && bus.apb_ready && !bus.apb_write) begin
        bus.rsp_rdata <= bus.apb_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pll_apb_cfg.sv
// Self-checking bench for pll_apb_cfg: APB responder, lock model and response scoreboard.
module tb_pll_apb_cfg;

  localparam int unsigned RT = 8;
  localparam int unsigned RC = 16;
  localparam int unsigned LT = 100;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        got;
    int          setup_cyc;
    int          access_cyc;
    int          access_len;
    int          rst_len;
    int          rst_fall;
    int          rsp_cyc;
    logic        hold_ok;
    logic [15:0] rdata;
    logic        err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_lock = 1'b0;
  logic pll_rst;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic        ready_en = 1'b1;
  int          wait_states = 0;
  logic [15:0] resp_data = 16'h0000;
  exp_t        sb[$];

  pll_apb_cfg_if bus();

  pll_apb_cfg #(
    .READY_TIMEOUT (RT),
    .RST_CYCLES    (RC),
    .LOCK_TIMEOUT  (LT)
  ) dut (
    .apb_clk   (clk),
    .apb_rst_n (rst_n),
    .bus       (bus),
    .pll_rst   (pll_rst),
    .pll_lock  (pll_lock)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // APB completer: inserts wait_states wait cycles, never answers when ready_en is low.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    bus.apb_ready = 1'b0;
    bus.apb_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.apb_sel && bus.apb_en) begin
        if (ready_en && acc_cnt >= wait_states) begin
          bus.apb_ready = 1'b1;
          bus.apb_rdata = resp_data;
        end else begin
          bus.apb_ready = 1'b0;
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        bus.apb_ready = 1'b0;
      end
    end
  end

  task automatic issue(input logic w, input logic [4:0] a, input logic [15:0] d,
                       input logic c, output int acc);
    bit ok;
    ok = 1'b0;
    acc = cyc;
    bus.cmd_write  = w;
    bus.cmd_addr   = a;
    bus.cmd_wdata  = d;
    bus.cmd_commit = c;
    bus.cmd_valid  = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_accept: cmd_ready got 0 want 1");
    end
  endtask

  task automatic run_txn(input logic w, input logic [4:0] a, input logic [15:0] d,
                         input logic c, input int lock_delay, input int bound,
                         output obs_t o);
    int   acc;
    int   rel;
    int   lock_at;
    logic prev_rst;
    o.got = 1'b0; o.setup_cyc = -1; o.access_cyc = -1; o.access_len = 0;
    o.rst_len = 0; o.rst_fall = -1; o.rsp_cyc = -1; o.hold_ok = 1'b1;
    o.rdata = 16'h0000; o.err = 1'b0;
    lock_at = -1;
    prev_rst = 1'b0;
    issue(w, a, d, c, acc);
    for (int k = 0; k < bound; k++) begin
      rel = cyc - acc;
      if (bus.apb_sel) begin
        if (!bus.apb_en && o.setup_cyc < 0) o.setup_cyc = rel;
        if (bus.apb_addr !== a || bus.apb_wdata !== d || bus.apb_write !== w) o.hold_ok = 1'b0;
      end
      if (bus.apb_sel && bus.apb_en) begin
        if (o.access_cyc < 0) o.access_cyc = rel;
        o.access_len++;
      end
      if (pll_rst) o.rst_len++;
      if (prev_rst && !pll_rst) begin
        o.rst_fall = rel;
        if (lock_delay >= 0) lock_at = cyc + lock_delay;
      end
      prev_rst = pll_rst;
      if (lock_at >= 0 && cyc == lock_at) pll_lock = 1'b1;
      if (bus.rsp_valid) begin
        o.got = 1'b1;
        o.rsp_cyc = rel;
        o.rdata = bus.rsp_rdata;
        o.err = bus.rsp_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.apb_sel, bus.apb_en, bus.apb_write, pll_rst} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 1000000", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err,
               bus.apb_sel, bus.apb_en, bus.apb_write, pll_rst});
    end
    checks++;
    if ({bus.apb_addr, bus.apb_wdata, bus.rsp_rdata} !== 37'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want all 0", bus.apb_addr, bus.apb_wdata, bus.rsp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_read();
    obs_t o;
    exp_t e;
    wait_states = 0; ready_en = 1'b1; resp_data = 16'hA5C3;
    sb.push_back({16'hA5C3, 1'b0});
    run_txn(1'b0, 5'h03, 16'h0000, 1'b0, -1, 20, o);
    checks++;
    if (o.setup_cyc !== 1 || o.access_cyc !== 2 || o.access_len !== 1 || o.rsp_cyc !== 3) begin
      errors++;
      $display("FAIL read_latency: setup=%0d access=%0d len=%0d rsp=%0d want 1 2 1 3",
               o.setup_cyc, o.access_cyc, o.access_len, o.rsp_cyc);
    end
    checks++;
    if (!o.got || sb.size() == 0) begin
      errors++; $display("FAIL read_rsp: got no response want rdata a5c3");
    end else begin
      e = sb.pop_front();
      if ({o.rdata, o.err} !== e) begin
        errors++; $display("FAIL read_rsp: got %h/%b want %h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
    // A read carrying cmd_commit must not pulse the PLL reset.
    wait_states = 1; resp_data = 16'h5A3C;
    sb.push_back({16'h5A3C, 1'b0});
    run_txn(1'b0, 5'h1F, 16'h0000, 1'b1, -1, 20, o);
    checks++;
    if (o.access_len !== 2 || o.rsp_cyc !== 4 || o.rst_len !== 0 || !o.hold_ok) begin
      errors++;
      $display("FAIL read_commit_ignored: len=%0d rsp=%0d rst=%0d hold=%b want 2 4 0 1",
               o.access_len, o.rsp_cyc, o.rst_len, o.hold_ok);
    end
    checks++;
    if (!o.got || sb.size() == 0) begin
      errors++; $display("FAIL read2_rsp: got no response want rdata 5a3c");
    end else begin
      e = sb.pop_front();
      if ({o.rdata, o.err} !== e) begin
        errors++; $display("FAIL read2_rsp: got %h/%b want %h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_commit_write();
    obs_t o;
    exp_t e;
    wait_states = 3; ready_en = 1'b1; pll_lock = 1'b0;
    sb.push_back({16'h0000, 1'b0});
    run_txn(1'b1, 5'h10, 16'h1234, 1'b1, 50, 200, o);
    checks++;
    if (o.access_len !== 4 || !o.hold_ok) begin
      errors++;
      $display("FAIL commit_access: len=%0d hold=%b want 4 1", o.access_len, o.hold_ok);
    end
    checks++;
    if (o.rst_len !== 16 || o.rst_fall !== 22) begin
      errors++;
      $display("FAIL commit_pll_rst: len=%0d fall=%0d want 16 22", o.rst_len, o.rst_fall);
    end
    checks++;
    if (o.rsp_cyc - o.rst_fall !== 53) begin
      errors++;
      $display("FAIL commit_lock_latency: got %0d want 53", o.rsp_cyc - o.rst_fall);
    end
    checks++;
    if (!o.got || sb.size() == 0) begin
      errors++; $display("FAIL commit_rsp: got no response want err 0");
    end else begin
      e = sb.pop_front();
      if ({o.rdata, o.err} !== e) begin
        errors++; $display("FAIL commit_rsp: got %h/%b want %h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ready_timeout();
    obs_t o;
    exp_t e;
    wait_states = 0; ready_en = 1'b0;
    sb.push_back({16'h0000, 1'b1});
    run_txn(1'b1, 5'h08, 16'hBEEF, 1'b1, -1, 50, o);
    checks++;
    if (o.access_len !== 8 || o.rsp_cyc !== 10 || o.rst_len !== 0) begin
      errors++;
      $display("FAIL ready_timeout: len=%0d rsp=%0d rst=%0d want 8 10 0", o.access_len, o.rsp_cyc, o.rst_len);
    end
    checks++;
    if (!o.got || sb.size() == 0) begin
      errors++; $display("FAIL ready_timeout_rsp: got no response want err 1");
    end else begin
      e = sb.pop_front();
      if ({o.rdata, o.err} !== e) begin
        errors++; $display("FAIL ready_timeout_rsp: got %h/%b want %h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
    ready_en = 1'b1;
  endtask

  task automatic test_lock_timeout();
    obs_t o;
    exp_t e;
    wait_states = 0; pll_lock = 1'b0;
    sb.push_back({16'h0000, 1'b1});
    run_txn(1'b1, 5'h11, 16'h00FF, 1'b1, -1, 300, o);
    checks++;
    if (o.rst_len !== 16 || o.rsp_cyc - o.rst_fall !== 100 || o.rsp_cyc !== 119) begin
      errors++;
      $display("FAIL lock_timeout: rst=%0d wait=%0d rsp=%0d want 16 100 119",
               o.rst_len, o.rsp_cyc - o.rst_fall, o.rsp_cyc);
    end
    checks++;
    if (!o.got || sb.size() == 0) begin
      errors++; $display("FAIL lock_timeout_rsp: got no response want err 1");
    end else begin
      e = sb.pop_front();
      if ({o.rdata, o.err} !== e) begin
        errors++; $display("FAIL lock_timeout_rsp: got %h/%b want %h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   n_acc;
    int   n_rsp;
    int   acc_at [3];
    logic overlap;
    exp_t e;
    n_acc = 0; n_rsp = 0; overlap = 1'b0;
    acc_at[0] = 0; acc_at[1] = 0; acc_at[2] = 0;
    wait_states = 0; ready_en = 1'b1;
    bus.cmd_write = 1'b0; bus.cmd_addr = 5'h05; bus.cmd_wdata = 16'h0000; bus.cmd_commit = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (n_acc >= 3) bus.cmd_valid = 1'b0;
      if (bus.cmd_ready && bus.apb_sel) overlap = 1'b1;
      if (bus.rsp_valid) begin
        n_rsp++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_rsp: unexpected response rdata=%h", bus.rsp_rdata);
        end else begin
          e = sb.pop_front();
          if ({bus.rsp_rdata, bus.rsp_err} !== e) begin
            errors++; $display("FAIL b2b_rsp: got %h/%b want %h/%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
          end
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (n_acc < 3) acc_at[n_acc] = cyc;
        n_acc++;
        resp_data = 16'hC000 + 16'(n_acc);
        sb.push_back({resp_data, 1'b0});
      end
      if (n_rsp == 3) break;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (n_acc !== 3 || n_rsp !== 3 || sb.size() !== 0 || overlap) begin
      errors++;
      $display("FAIL b2b_count: acc=%0d rsp=%0d left=%0d overlap=%b want 3 3 0 0", n_acc, n_rsp, sb.size(), overlap);
    end
    checks++;
    if (acc_at[1] - acc_at[0] !== 4 || acc_at[2] - acc_at[1] !== 4) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d %0d want 4 4", acc_at[1] - acc_at[0], acc_at[2] - acc_at[1]);
    end
  endtask

  task automatic test_reset_in_rst_pll();
    int   acc;
    logic seen;
    logic stray;
    obs_t o;
    exp_t e;
    seen = 1'b0; stray = 1'b0;
    wait_states = 0; pll_lock = 1'b0;
    issue(1'b1, 5'h12, 16'hCAFE, 1'b1, acc);
    for (int k = 0; k < 20; k++) begin
      if (pll_rst) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL abort_enter_rst: pll_rst got 0 want 1");
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({pll_rst, bus.cmd_ready, bus.apb_sel, bus.rsp_valid} !== 4'b0100) begin
      errors++;
      $display("FAIL abort_reset: got %b want 0100", {pll_rst, bus.cmd_ready, bus.apb_sel, bus.rsp_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus.rsp_valid || pll_rst) stray = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (stray || sb.size() !== 0) begin
      errors++; $display("FAIL abort_no_rsp: stray=%b left=%0d want 0 0", stray, sb.size());
    end
    resp_data = 16'h0F0F;
    sb.push_back({16'h0F0F, 1'b0});
    run_txn(1'b0, 5'h02, 16'h0000, 1'b0, -1, 20, o);
    checks++;
    if (!o.got || sb.size() == 0 || o.rsp_cyc !== 3) begin
      errors++; $display("FAIL recover_rsp: got=%b rsp=%0d want 1 3", o.got, o.rsp_cyc);
    end else begin
      e = sb.pop_front();
      if ({o.rdata, o.err} !== e) begin
        errors++; $display("FAIL recover_rsp: got %h/%b want %h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = 5'h00;
    bus.cmd_wdata  = 16'h0000;
    bus.cmd_commit = 1'b0;
    test_reset();
    test_read();
    test_commit_write();
    test_ready_timeout();
    test_lock_timeout();
    test_back_to_back();
    test_reset_in_rst_pll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
